// File: rtl/mdio_ctrl_if.sv
// Host-side request/response bundle of the MDIO management controller.
// The master drives a transaction request; the slave (mdio_ctrl) reports completion.
interface mdio_ctrl_if;
  logic        req;
  logic        we;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;

  modport master (
    output req, we, phy_addr, reg_addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, phy_addr, reg_addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mdio_ctrl.sv
// IEEE 802.3 clause 22 MDIO management master: serialises one read/write frame per request.
// Define MDIO_PREAMBLE_EN to send the 32-bit preamble; otherwise frames start at ST (32 bits).
module mdio_ctrl #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  mdio_ctrl_if.slave host,
  output logic       ETH_PHY_MDC,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic       mdio_i
);

  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, DONE} state_t;

  localparam logic [8:0] HALF = 9'(CLK_DIV);
  localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

`ifdef MDIO_PREAMBLE_EN
  localparam state_t     FIRST_STATE = PRE;
  localparam logic [6:0] FIRST_BIT   = 7'd0;
`else
  localparam state_t     FIRST_STATE = CMD;
  localparam logic [6:0] FIRST_BIT   = 7'd32;
`endif

  state_t      state, next_state;
  logic [8:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic [63:0] frame;
  logic        is_write;
  logic [15:0] rx_sh;
  logic [15:0] rdata_q;
  logic        mdc_q, mdio_o_q, mdio_oe_q, busy_q, ack_q;
  logic        mdc_d, mdio_o_d, mdio_oe_d, busy_d, ack_d;
  logic        in_frame, bit_start, mdc_rise, bit_end, drive_bit;
  logic [5:0]  bit_idx;

  // bit_cnt is a frame-wide position 0..63; the segment it falls in names the state
  function automatic state_t bit_state(input logic [6:0] b);
    if (b < 7'd32)      return PRE;
    else if (b < 7'd46) return CMD;
    else if (b < 7'd48) return TA;
    else if (b < 7'd64) return DATA;
    else                return DONE;
  endfunction

  assign in_frame  = (state == PRE) || (state == CMD) || (state == TA) || (state == DATA);
  assign bit_start = (div_cnt == 9'd0);
  assign mdc_rise  = (div_cnt == HALF);
  assign bit_end   = (div_cnt == LAST);
  assign bit_idx   = ~bit_cnt[5:0];
  assign drive_bit = is_write || (bit_cnt < 7'd46);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    mdc_d      = mdc_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    unique case (state)
      IDLE: begin
        mdc_d     = 1'b0;
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b0;
        if (host.req) next_state = FIRST_STATE;
      end
      PRE, CMD, TA, DATA: begin
        if (bit_start) begin
          next_state = bit_state(bit_cnt);
          mdc_d      = 1'b0;
          if (bit_cnt == 7'd64) begin
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
          end else begin
            // A read hands the line to the PHY from the first TA bit onward
            mdio_o_d  = drive_bit ? frame[bit_idx] : 1'b1;
            mdio_oe_d = drive_bit;
          end
        end else if (mdc_rise) begin
          mdc_d = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        mdc_d      = 1'b0;
        mdio_o_d   = 1'b1;
        mdio_oe_d  = 1'b0;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy_d = (state != IDLE) &&
                  ((next_state == PRE) || (next_state == CMD) ||
                   (next_state == TA)  || (next_state == DATA));
  assign ack_d  = (state != DONE) && (next_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      is_write  <= 1'b0;
      rx_sh     <= '0;
      rdata_q   <= '0;
      mdc_q     <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      mdc_q     <= mdc_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      if (state == IDLE && host.req) begin
        frame    <= {32'hFFFF_FFFF, 2'b01, (host.we ? 2'b01 : 2'b10),
                     host.phy_addr, host.reg_addr, 2'b10, host.wdata};
        is_write <= host.we;
        rx_sh    <= '0;
        div_cnt  <= '0;
        bit_cnt  <= FIRST_BIT;
      end else if (in_frame) begin
        div_cnt <= bit_end ? 9'd0 : div_cnt + 9'd1;
        if (bit_end) bit_cnt <= bit_cnt + 7'd1;
        if (mdc_rise && state == DATA && !is_write) rx_sh <= {rx_sh[14:0], mdio_i};
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end
      if (ack_d && !is_write) rdata_q <= rx_sh;
    end
  end

  assign ETH_PHY_MDC = mdc_q;
  assign mdio_o      = mdio_o_q;
  assign mdio_oe     = mdio_oe_q;
  assign host.busy   = busy_q;
  assign host.ack    = ack_q;
  assign host.rdata  = rdata_q;

endmodule

// File: tb/tb_mdio_ctrl.sv
// Bench for mdio_ctrl: a CLK_DIV=2 instance with a PHY read model plus a CLK_DIV=1 instance.
// Expected frame bits and read data are queued at request time and compared after ack.
module tb_mdio_ctrl;

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE_BITS = 32;
`else
  localparam int PRE_BITS = 0;
`endif
  localparam int FRAME = PRE_BITS + 32;
  localparam int D0    = 2;
  localparam int D1    = 1;
  localparam int NOM0  = 1 + FRAME * 2 * D0;
  localparam int NOM1  = 1 + FRAME * 2 * D1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdio_ctrl_if bus0();
  mdio_ctrl_if bus1();
  logic mdc0, mdo0, mdoe0;
  logic mdc1, mdo1, mdoe1;
  logic mdi0 = 1'b1;
  logic mdi1 = 1'b1;

  mdio_ctrl #(.CLK_DIV(D0)) dut0 (
    .clk(clk), .rst(rst), .host(bus0),
    .ETH_PHY_MDC(mdc0), .mdio_o(mdo0), .mdio_oe(mdoe0), .mdio_i(mdi0)
  );

  mdio_ctrl #(.CLK_DIV(D1)) dut1 (
    .clk(clk), .rst(rst), .host(bus1),
    .ETH_PHY_MDC(mdc1), .mdio_o(mdo1), .mdio_oe(mdoe1), .mdio_i(mdi1)
  );

  int total = 0;
  int bad   = 0;

  logic        exp_q[$];
  logic [15:0] exp_rd_q[$];
  logic        obs0_q[$];
  logic        obs1_q[$];
  int          obs_mark;
  logic [15:0] model_rdata;

  int          rise_cnt0 = 0;
  int          phy_base  = 0;
  logic        phy_on    = 1'b0;
  logic [15:0] phy_data  = '0;

  // Driven bits are captured where the PHY would latch them: MDC rising
  always @(posedge mdc0) begin
    rise_cnt0 = rise_cnt0 + 1;
    if (mdoe0 === 1'b1) obs0_q.push_back(mdo0);
  end

  always @(posedge mdc1) begin
    if (mdoe1 === 1'b1) obs1_q.push_back(mdo1);
  end

  // PHY model presents each read-data bit after MDC falls
  always @(negedge mdc0) begin
    int r;
    r = rise_cnt0 - phy_base;
    if (phy_on && r >= 0 && r < 16) mdi0 = phy_data[15 - r];
    else                            mdi0 = 1'b1;
  end

  task automatic do_frame(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic [15:0] pd, input int extra_at,
                          output int ack_at, output int busy_cyc, output logic [15:0] rd_at_ack);
    int cyc;
    for (int i = 0; i < PRE_BITS; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(w ? 1'b0 : 1'b1);
    exp_q.push_back(w ? 1'b1 : 1'b0);
    for (int i = 4; i >= 0; i--) exp_q.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) exp_q.push_back(ra[i]);
    if (w) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) exp_q.push_back(wd[i]);
    end
    exp_rd_q.push_back(w ? model_rdata : pd);
    if (!w) model_rdata = pd;

    @(negedge clk);
    obs_mark      = obs0_q.size();
    phy_data      = pd;
    phy_on        = !w;
    phy_base      = rise_cnt0 + PRE_BITS + 16;
    bus0.we       = w;
    bus0.phy_addr = pa;
    bus0.reg_addr = ra;
    bus0.wdata    = wd;
    bus0.req      = 1'b1;
    @(posedge clk);
    cyc       = 0;
    ack_at    = -1;
    busy_cyc  = 0;
    rd_at_ack = 'x;
    while (ack_at < 0 && cyc <= NOM0 + 20) begin
      @(negedge clk);
      if (cyc == 0) bus0.req = 1'b0;
      if (cyc == extra_at) begin
        bus0.req      = 1'b1;
        bus0.we       = ~w;
        bus0.phy_addr = ~pa;
        bus0.wdata    = ~wd;
      end
      if (extra_at >= 0 && cyc == extra_at + 1) bus0.req = 1'b0;
      if (bus0.busy === 1'b1) busy_cyc++;
      if (bus0.ack === 1'b1) begin
        ack_at    = cyc;
        rd_at_ack = bus0.rdata;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.phy_addr = '0; bus0.reg_addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.phy_addr = '0; bus1.reg_addr = '0; bus1.wdata = '0;
    model_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    total++; if (mdc0 !== 1'b0)  begin bad++; $display("[TB] FAIL reset_mdc: got %b want 0", mdc0); end
    total++; if (mdo0 !== 1'b1)  begin bad++; $display("[TB] FAIL reset_mdio_o: got %b want 1", mdo0); end
    total++; if (mdoe0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_mdio_oe: got %b want 0", mdoe0); end
    total++; if (bus0.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus0.busy); end
    total++; if (bus0.ack !== 1'b0)  begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", bus0.ack); end
    total++; if (bus0.rdata !== 16'h0000) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0000", bus0.rdata); end
    total++; if (mdc1 !== 1'b0 || mdoe1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_dut1: got mdc=%b oe=%b want 0 0", mdc1, mdoe1); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (mdc0 !== 1'b0 || mdoe0 !== 1'b0 || bus0.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_lines: got mdc=%b oe=%b busy=%b want 0 0 0", mdc0, mdoe0, bus0.busy);
    end
  endtask

  task automatic test_write;
    int ack_at, busy_cyc, n_exp, n_obs, first_bad;
    logic [15:0] rd, exp_rd;
    logic eb;
    do_frame(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, -1, ack_at, busy_cyc, rd);
    total++; if (ack_at !== NOM0) begin bad++; $display("[TB] FAIL write_ack_latency: got %0d want %0d", ack_at, NOM0); end
    total++; if (busy_cyc !== NOM0 - 1) begin bad++; $display("[TB] FAIL write_busy_cycles: got %0d want %0d", busy_cyc, NOM0 - 1); end
    exp_rd = exp_rd_q.pop_front();
    total++; if (rd !== exp_rd) begin bad++; $display("[TB] FAIL write_rdata_kept: got %h want %h", rd, exp_rd); end
    n_exp = exp_q.size(); n_obs = obs0_q.size() - obs_mark; first_bad = -1;
    for (int i = 0; i < n_exp; i++) begin
      eb = exp_q.pop_front();
      if (i < n_obs && first_bad < 0 && obs0_q[obs_mark + i] !== eb) first_bad = i;
    end
    total++; if (n_obs != n_exp || first_bad >= 0) begin
      bad++; $display("[TB] FAIL write_stream: got %0d bits (first diff at %0d) want %0d bits", n_obs, first_bad, n_exp);
    end
    @(negedge clk);
    total++; if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL write_ack_pulse: got ack=%b busy=%b want 0 0", bus0.ack, bus0.busy);
    end
  endtask

  task automatic test_read;
    int ack_at, busy_cyc, n_exp, n_obs, first_bad;
    logic [15:0] rd, exp_rd;
    logic eb;
    do_frame(1'b0, 5'h01, 5'h02, 16'hFFFF, 16'h0022, -1, ack_at, busy_cyc, rd);
    total++; if (ack_at !== NOM0) begin bad++; $display("[TB] FAIL read_ack_latency: got %0d want %0d", ack_at, NOM0); end
    exp_rd = exp_rd_q.pop_front();
    total++; if (rd !== exp_rd) begin bad++; $display("[TB] FAIL read_rdata: got %h want %h", rd, exp_rd); end
    n_exp = exp_q.size(); n_obs = obs0_q.size() - obs_mark; first_bad = -1;
    for (int i = 0; i < n_exp; i++) begin
      eb = exp_q.pop_front();
      if (i < n_obs && first_bad < 0 && obs0_q[obs_mark + i] !== eb) first_bad = i;
    end
    total++; if (n_obs != n_exp || first_bad >= 0) begin
      bad++; $display("[TB] FAIL read_stream_release: got %0d driven bits (first diff at %0d) want %0d", n_obs, first_bad, n_exp);
    end
  endtask

  task automatic test_ignore_req;
    int ack_at, busy_cyc, n_exp, n_obs, first_bad, late;
    logic [15:0] rd, exp_rd;
    logic eb;
    do_frame(1'b1, 5'h0A, 5'h15, 16'hC3A5, 16'h0000, 40, ack_at, busy_cyc, rd);
    total++; if (ack_at !== NOM0) begin bad++; $display("[TB] FAIL ignore_ack_latency: got %0d want %0d", ack_at, NOM0); end
    exp_rd = exp_rd_q.pop_front();
    total++; if (rd !== exp_rd) begin bad++; $display("[TB] FAIL ignore_rdata: got %h want %h", rd, exp_rd); end
    n_exp = exp_q.size(); n_obs = obs0_q.size() - obs_mark; first_bad = -1;
    for (int i = 0; i < n_exp; i++) begin
      eb = exp_q.pop_front();
      if (i < n_obs && first_bad < 0 && obs0_q[obs_mark + i] !== eb) first_bad = i;
    end
    total++; if (n_obs != n_exp || first_bad >= 0) begin
      bad++; $display("[TB] FAIL ignore_stream: got %0d bits (first diff at %0d) want %0d bits", n_obs, first_bad, n_exp);
    end
    late = 0;
    for (int c = 0; c < 2 * NOM0; c++) begin
      @(negedge clk);
      if (bus0.ack === 1'b1 || bus0.busy === 1'b1) late++;
    end
    total++; if (late != 0) begin bad++; $display("[TB] FAIL ignore_no_queue: got %0d busy/ack cycles want 0", late); end
  endtask

  task automatic test_back_to_back;
    int ack_a, busy_a, ack_b, busy_b, n_exp, n_obs, first_bad;
    logic [15:0] rd_a, rd_b, exp_rd;
    logic eb;
    do_frame(1'b0, 5'h07, 5'h11, 16'h0000, 16'hBEEF, -1, ack_a, busy_a, rd_a);
    // Second request lands in the cycle right after the first ack
    do_frame(1'b1, 5'h02, 5'h03, 16'h8001, 16'h0000, -1, ack_b, busy_b, rd_b);
    exp_rd = exp_rd_q.pop_front();
    total++; if (rd_a !== exp_rd) begin bad++; $display("[TB] FAIL b2b_read_rdata: got %h want %h", rd_a, exp_rd); end
    exp_rd = exp_rd_q.pop_front();
    total++; if (rd_b !== exp_rd) begin bad++; $display("[TB] FAIL b2b_rdata_after_write: got %h want %h", rd_b, exp_rd); end
    total++; if (ack_b !== NOM0 || busy_b !== NOM0 - 1) begin
      bad++; $display("[TB] FAIL b2b_second_timing: got ack=%0d busy=%0d want %0d %0d", ack_b, busy_b, NOM0, NOM0 - 1);
    end
    n_exp = exp_q.size(); n_obs = obs0_q.size() - obs_mark; first_bad = -1;
    for (int i = 0; i < n_exp; i++) begin
      eb = exp_q.pop_front();
      if (i >= n_exp - (n_obs) && first_bad < 0 && obs0_q[obs_mark + i - (n_exp - n_obs)] !== eb) first_bad = i;
    end
    total++; if (n_exp != (PRE_BITS + 14) + n_obs || first_bad >= 0) begin
      bad++; $display("[TB] FAIL b2b_write_stream: got %0d bits (first diff at %0d) want %0d bits", n_obs, first_bad, n_exp - PRE_BITS - 14);
    end
  endtask

  task automatic test_reset_mid;
    int t_abort, acks;
    @(negedge clk);
    bus0.we = 1'b1; bus0.phy_addr = 5'h1F; bus0.reg_addr = 5'h1F; bus0.wdata = 16'hA5A5;
    phy_on = 1'b0;
    bus0.req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.req = 1'b0;
    t_abort = 1 + 2 * D0 * (PRE_BITS + 16 + 5) + 1;
    repeat (t_abort) @(negedge clk);
    total++; if (bus0.busy !== 1'b1 || mdoe0 !== 1'b1) begin
      bad++; $display("[TB] FAIL abort_precondition: got busy=%b oe=%b want 1 1", bus0.busy, mdoe0);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (mdc0 !== 1'b0 || mdoe0 !== 1'b0 || bus0.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_lines: got mdc=%b oe=%b busy=%b want 0 0 0", mdc0, mdoe0, bus0.busy);
    end
    rst = 1'b0;
    model_rdata = '0;
    acks = 0;
    for (int c = 0; c < 2 * NOM0; c++) begin
      @(negedge clk);
      if (bus0.ack === 1'b1) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("[TB] FAIL abort_no_ack: got %0d acks want 0", acks); end
    total++; if (bus0.rdata !== 16'h0000) begin bad++; $display("[TB] FAIL abort_rdata: got %h want 0000", bus0.rdata); end
  endtask

  task automatic test_div1_frame;
    int cyc, ack_at, mark;
    logic [3:0] head, exp_head;
    mark = obs1_q.size();
    exp_head = 4'b0101;
    @(negedge clk);
    bus1.we = 1'b1; bus1.phy_addr = 5'h03; bus1.reg_addr = 5'h04; bus1.wdata = 16'h5A5A;
    bus1.req = 1'b1;
    @(posedge clk);
    cyc = 0;
    ack_at = -1;
    while (ack_at < 0 && cyc <= NOM1 + 20) begin
      @(negedge clk);
      if (cyc == 0) bus1.req = 1'b0;
      if (bus1.ack === 1'b1) ack_at = cyc;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    total++; if (ack_at !== NOM1) begin bad++; $display("[TB] FAIL div1_ack_latency: got %0d want %0d", ack_at, NOM1); end
    head = 'x;
    if (obs1_q.size() >= mark + PRE_BITS + 4)
      for (int i = 0; i < 4; i++) head[3 - i] = obs1_q[mark + PRE_BITS + i];
    total++; if (head !== exp_head || obs1_q.size() != mark + FRAME) begin
      bad++; $display("[TB] FAIL div1_frame_start: got head=%b bits=%0d want %b bits=%0d", head, obs1_q.size() - mark, exp_head, FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_req();
    test_back_to_back();
    test_reset_mid();
    test_div1_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
